// File: rtl/alu_control_sequencer_pkg.sv
// Shared constants for the ALU control sequencer: opcodes, T-states and
// control-word bit positions.
package alu_ctrl_pkg;

  localparam int OPCODE_W = 4;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_LDA = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_STA = 4'b0100;
  localparam logic [3:0] OP_LDI = 4'b0101;
  localparam logic [3:0] OP_JMP = 4'b0110;
  localparam logic [3:0] OP_JC  = 4'b0111;
  localparam logic [3:0] OP_JZ  = 4'b1000;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } step_t;

  localparam int CW_W   = 16;
  localparam int CW_HLT = 15;
  localparam int CW_MI  = 14;
  localparam int CW_RI  = 13;
  localparam int CW_RO  = 12;
  localparam int CW_II  = 11;
  localparam int CW_IO  = 10;
  localparam int CW_AI  = 9;
  localparam int CW_AO  = 8;
  localparam int CW_BI  = 7;
  localparam int CW_E0  = 6;
  localparam int CW_SU  = 5;
  localparam int CW_FI  = 4;
  localparam int CW_OI  = 3;
  localparam int CW_CE  = 2;
  localparam int CW_CO  = 1;
  localparam int CW_J   = 0;

  typedef logic [CW_W-1:0] ctrl_word_t;

  // One-hot control word with only the given line asserted.
  function automatic ctrl_word_t cw_bit(input int idx);
    ctrl_word_t w;
    w      = '0;
    w[idx] = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/alu_control_sequencer_if.sv
// Sequencer-to-datapath bundle: opcode/flags in, T-state and control lines out.
interface alu_control_sequencer_if
  import alu_ctrl_pkg::*;
#(
  parameter int OP_W = OPCODE_W
);
  logic [OP_W-1:0] OP;
  logic            CF;
  logic            ZF;
  logic [2:0]      STEP;
  logic HLT, MI, RI, RO, II, IO, AI, AO, BI, E0, SU, FI, OI, CE, CO, J;

  modport master (
    input  OP, CF, ZF,
    output STEP, HLT, MI, RI, RO, II, IO, AI, AO, BI, E0, SU, FI, OI, CE, CO, J
  );

  modport slave (
    output OP, CF, ZF,
    input  STEP, HLT, MI, RI, RO, II, IO, AI, AO, BI, E0, SU, FI, OI, CE, CO, J
  );
endinterface

// File: rtl/alu_control_sequencer_microcode.sv
// Combinational microcode ROM: (step, op, cf, zf) -> control word and a flag
// marking the instruction's final micro-step.
module seq_microcode
  import alu_ctrl_pkg::*;
(
  input  step_t                step,
  input  logic [OPCODE_W-1:0]  op,
  input  logic                 cf,
  input  logic                 zf,
  output ctrl_word_t           ctrl_word,
  output logic                 last_step
);

  // Decode the micro-step; unreachable combinations give an empty word and end the instruction.
  always_comb begin
    ctrl_word = '0;
    last_step = 1'b0;
    case (step)
      T0: ctrl_word = cw_bit(CW_CO) | cw_bit(CW_MI);
      T1: ctrl_word = cw_bit(CW_RO) | cw_bit(CW_II) | cw_bit(CW_CE);
      T2: begin
        case (op)
          OP_LDA, OP_ADD, OP_SUB, OP_STA:
            ctrl_word = cw_bit(CW_IO) | cw_bit(CW_MI);
          OP_LDI: begin
            ctrl_word = cw_bit(CW_IO) | cw_bit(CW_AI);
            last_step = 1'b1;
          end
          OP_JMP: begin
            ctrl_word = cw_bit(CW_IO) | cw_bit(CW_J);
            last_step = 1'b1;
          end
          OP_JC: begin
            ctrl_word = cw_bit(CW_IO) | (cf ? cw_bit(CW_J) : '0);
            last_step = 1'b1;
          end
          OP_JZ: begin
            ctrl_word = cw_bit(CW_IO) | (zf ? cw_bit(CW_J) : '0);
            last_step = 1'b1;
          end
          OP_OUT: begin
            ctrl_word = cw_bit(CW_AO) | cw_bit(CW_OI);
            last_step = 1'b1;
          end
          OP_HLT: begin
            ctrl_word = cw_bit(CW_HLT);
            last_step = 1'b1;
          end
          default: last_step = 1'b1;
        endcase
      end
      T3: begin
        case (op)
          OP_LDA: begin
            ctrl_word = cw_bit(CW_RO) | cw_bit(CW_AI);
            last_step = 1'b1;
          end
          OP_ADD, OP_SUB:
            ctrl_word = cw_bit(CW_RO) | cw_bit(CW_BI);
          OP_STA: begin
            ctrl_word = cw_bit(CW_AO) | cw_bit(CW_RI);
            last_step = 1'b1;
          end
          default: last_step = 1'b1;
        endcase
      end
      T4: begin
        last_step = 1'b1;
        case (op)
          OP_ADD:  ctrl_word = cw_bit(CW_E0) | cw_bit(CW_AI) | cw_bit(CW_FI);
          OP_SUB:  ctrl_word = cw_bit(CW_E0) | cw_bit(CW_AI) | cw_bit(CW_SU) | cw_bit(CW_FI);
          default: ctrl_word = '0;
        endcase
      end
      default: last_step = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_control_sequencer.sv
// ALU control sequencer top: step/halt registers, next-step logic and
// reset gating of the decoded control word.
//
//   state     | meaning
//   T0        | fetch: PC onto bus, load MAR
//   T1        | fetch: RAM into IR, increment PC
//   T2..T4    | execute micro-steps, length depends on opcode
//   halted    | frozen at T2 with HLT=1 until CLR
module alu_control_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int OP_W = 4
) (
  input  logic                    CLK,
  input  logic                    CLR,
  alu_control_sequencer_if.master bus
);

  step_t      step_q, step_d;
  logic       halted_q, halted_d;
  logic [OP_W-1:0] op;
  ctrl_word_t cw_dec;
  logic       last_step;
  ctrl_word_t cw_out;
  logic [2:0] step_out;

  assign op = bus.OP;

  seq_microcode u_microcode (
    .step      (step_q),
    .op        (op),
    .cf        (bus.CF),
    .zf        (bus.ZF),
    .ctrl_word (cw_dec),
    .last_step (last_step)
  );

  // Step and halt registers with synchronous clear.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      step_q   <= T0;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      halted_q <= halted_d;
    end
  end

  // Advance the T-state; HLT parks the sequencer at T2 instead of wrapping.
  always_comb begin
    step_d   = step_q;
    halted_d = halted_q;
    if (!halted_q) begin
      if (step_q == T2 && op == OP_HLT) begin
        halted_d = 1'b1;
      end else if (last_step) begin
        step_d = T0;
      end else begin
        step_d = step_t'(step_q + 3'd1);
      end
    end
  end

  // Drive the control word: zero under CLR, HLT-only while halted, else the decode.
  always_comb begin
    cw_out   = '0;
    step_out = 3'd0;
    if (!CLR) begin
      step_out = step_q;
      cw_out   = halted_q ? cw_bit(CW_HLT) : cw_dec;
    end
  end

  assign bus.STEP = step_out;
  assign bus.HLT  = cw_out[CW_HLT];
  assign bus.MI   = cw_out[CW_MI];
  assign bus.RI   = cw_out[CW_RI];
  assign bus.RO   = cw_out[CW_RO];
  assign bus.II   = cw_out[CW_II];
  assign bus.IO   = cw_out[CW_IO];
  assign bus.AI   = cw_out[CW_AI];
  assign bus.AO   = cw_out[CW_AO];
  assign bus.BI   = cw_out[CW_BI];
  assign bus.E0   = cw_out[CW_E0];
  assign bus.SU   = cw_out[CW_SU];
  assign bus.FI   = cw_out[CW_FI];
  assign bus.OI   = cw_out[CW_OI];
  assign bus.CE   = cw_out[CW_CE];
  assign bus.CO   = cw_out[CW_CO];
  assign bus.J    = cw_out[CW_J];

endmodule
